hk_apb_arbiter: RTL and testbench
=================================

// Module: hk_apb_arbiter
// PURPOSE
//  Shares the single housekeeping Wishbone slave port between two APB requesters:
//  port 0 is the CPU APB path (0x2600_0000 window) and port 1 is the debug/SPI-side master.
//  Round-robin arbitration, one outstanding WB cycle, and a bus-timeout watchdog that returns
//  PSLVERR when the housekeeping block never acks. Sits between the APB splitter and housekeeping.
// PARAMETERS
//  W_ADDR          32   address width of APB ports and wb_adr_o
//  TIMEOUT_CYCLES  255  WB cycles without ack before abort; 0 disables timeout
// PORTS
//  clk              in   1       system clock (housekeeping clock domain)
//  rst_n            in   1       asynchronous, active-low reset
//  s0_paddr/s1_paddr      in  W_ADDR  APB address, per port
//  s0_psel/s1_psel        in  1       APB select
//  s0_penable/s1_penable  in  1       APB access phase
//  s0_pwrite/s1_pwrite    in  1       1 = write
//  s0_pwdata/s1_pwdata    in  32      write data
//  s0_pready/s1_pready    out 1       transfer complete
//  s0_prdata/s1_prdata    out 32      read data, valid only with pready
//  s0_pslverr/s1_pslverr  out 1       timeout error, valid only with pready
//  wb_cyc_o, wb_stb_o     out 1       WB cycle/strobe to housekeeping
//  wb_we_o          out  1       WB write enable
//  wb_sel_o         out  4       byte select, constant 4'hF
//  wb_adr_o         out  W_ADDR  latched address of granted port
//  wb_dat_o         out  32      latched write data
//  wb_dat_i         in   32      WB read data
//  wb_ack_i         in   1       WB acknowledge
//  timeout_count    out  8       saturating count of timed-out transfers (diagnostic)
// BEHAVIOUR
//  Reset (async): FSM=IDLE; all outputs 0 except wb_sel_o=4'hF; last_grant=1 (port 0 wins first tie);
//   timeout_count=0. Reset mid-transfer abandons the WB cycle immediately (cyc/stb drop async).
//  FSM IDLE -> BUS -> RESP -> IDLE.
//  IDLE: request_k = sK_psel. If exactly one requests, grant it; if both, grant !last_grant.
//   On grant: latch paddr, pwdata, pwrite of granted port; clear timer; next = BUS.
//  BUS: wb_cyc_o=wb_stb_o=1, wb_we_o/adr/dat from latches. Timer increments each BUS cycle.
//   wb_ack_i=1 -> latch wb_dat_i (reads only; writes latch 0), err=0, next = RESP.
//   else if TIMEOUT_CYCLES!=0 and timer==TIMEOUT_CYCLES-1 -> err=1, rdata=0,
//   timeout_count+=1 (saturate at 255), next = RESP. Ack in same cycle as timeout wins.
//   cyc/stb deassert in the cycle after ack/timeout (registered outputs, no back-to-back strobe).
//  RESP: if granted psel & penable: pready_g=1, prdata_g=rdata, pslverr_g=err for exactly
//   one cycle; last_grant=g; next = IDLE. If granted psel is low (master abandoned, protocol
//   violation): drop response, update last_grant, next = IDLE. Otherwise wait in RESP.
//  Non-granted / idle port: pready=0, prdata=0, pslverr=0 at all times (APB wait states).
//   A request arriving while busy is held by the master and served on return to IDLE.
//  Latency: setup at T0 (IDLE), BUS at T1, ack at T1 -> RESP/pready at T2: minimum
//   3-cycle APB transfer (one wait state). Timeout: pready TIMEOUT_CYCLES+1 cycles after T0.
//  Fairness: with both ports continuously requesting, grants strictly alternate 0,1,0,1...
//  Timer width = $clog2(TIMEOUT_CYCLES+1), min 1; never wraps (cleared on grant).
// TESTING
//  1. Port0 read 0x2600_0004, WB acks at T1 with 0x1234_5678 -> s0_pready at T2,
//     s0_prdata=0x1234_5678, s0_pslverr=0, wb_stb_o high exactly 1 cycle, wb_sel_o=4'hF.
//  2. Both psel rise same cycle after reset, writes 0xA/0xB -> port0 served first, then port1;
//     wb_dat_o sequence 0xA then 0xB; s1_pready stays 0 until its own RESP.
//  3. Both ports back-to-back for 8 transfers -> grant order 0,1,0,1,0,1,0,1.
//  4. TIMEOUT_CYCLES=4, wb_ack_i held 0 -> 4 BUS cycles, then pready=1, pslverr=1, prdata=0,
//     timeout_count=1; ack arriving in 4th BUS cycle -> pslverr=0 instead.
//  5. Assert rst_n low during BUS -> wb_cyc_o/wb_stb_o/pready fall same cycle; after release
//     port0 wins the next tie and timeout_count=0.
//  6. Force 256 timeouts -> timeout_count saturates at 255.

Source files
------------

// File: rtl/hk_apb_arbiter_if.sv
// Bus bundle for the housekeeping APB arbiter: two APB requester ports
// plus the Wishbone master side that drives the housekeeping block.
interface hk_apb_arbiter_if #(
  parameter int W_ADDR = 32
);
  logic [W_ADDR-1:0] s0_paddr;
  logic              s0_psel;
  logic              s0_penable;
  logic              s0_pwrite;
  logic [31:0]       s0_pwdata;
  logic              s0_pready;
  logic [31:0]       s0_prdata;
  logic              s0_pslverr;

  logic [W_ADDR-1:0] s1_paddr;
  logic              s1_psel;
  logic              s1_penable;
  logic              s1_pwrite;
  logic [31:0]       s1_pwdata;
  logic              s1_pready;
  logic [31:0]       s1_prdata;
  logic              s1_pslverr;

  logic              wb_cyc_o;
  logic              wb_stb_o;
  logic              wb_we_o;
  logic [3:0]        wb_sel_o;
  logic [W_ADDR-1:0] wb_adr_o;
  logic [31:0]       wb_dat_o;
  logic [31:0]       wb_dat_i;
  logic              wb_ack_i;

  // The arbiter is the APB completer for both requesters and the WB initiator
  modport slave (
    input  s0_paddr, s0_psel, s0_penable, s0_pwrite, s0_pwdata,
    output s0_pready, s0_prdata, s0_pslverr,
    input  s1_paddr, s1_psel, s1_penable, s1_pwrite, s1_pwdata,
    output s1_pready, s1_prdata, s1_pslverr,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i
  );

  modport master (
    output s0_paddr, s0_psel, s0_penable, s0_pwrite, s0_pwdata,
    input  s0_pready, s0_prdata, s0_pslverr,
    output s1_paddr, s1_psel, s1_penable, s1_pwrite, s1_pwdata,
    input  s1_pready, s1_prdata, s1_pslverr,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/hk_apb_arbiter.sv
// Round-robin arbiter sharing the housekeeping Wishbone port between two APB
// requesters, with one outstanding WB cycle and a no-ack timeout watchdog.
module hk_apb_arbiter #(
  parameter int W_ADDR         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  hk_apb_arbiter_if.slave  bus,
  output logic [7:0]       timeout_count
);

  localparam int TW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic              grant;
  logic              last_grant;
  logic [W_ADDR-1:0] adr_q;
  logic [31:0]       wdat_q;
  logic              we_q;
  logic              cyc_q;
  logic [31:0]       rdata;
  logic              err;
  logic [TW-1:0]     timer;

  logic any_req;
  logic pick;
  logic gsel;
  logic gen;
  logic resp_hit;

  // On a tie the port that was not served last wins, giving strict alternation
  always_comb begin
    any_req  = bus.s0_psel | bus.s1_psel;
    pick     = (bus.s0_psel & bus.s1_psel) ? ~last_grant : bus.s1_psel;
    gsel     = grant ? bus.s1_psel    : bus.s0_psel;
    gen      = grant ? bus.s1_penable : bus.s0_penable;
    resp_hit = (state == RESP) & gsel & gen;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      grant         <= 1'b0;
      last_grant    <= 1'b1;
      adr_q         <= '0;
      wdat_q        <= '0;
      we_q          <= 1'b0;
      cyc_q         <= 1'b0;
      rdata         <= '0;
      err           <= 1'b0;
      timer         <= '0;
      timeout_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant  <= pick;
            adr_q  <= pick ? bus.s1_paddr  : bus.s0_paddr;
            wdat_q <= pick ? bus.s1_pwdata : bus.s0_pwdata;
            we_q   <= pick ? bus.s1_pwrite : bus.s0_pwrite;
            timer  <= '0;
            cyc_q  <= 1'b1;
            state  <= BUS;
          end
        end
        BUS: begin
          if (timer != '1) begin
            timer <= timer + 1'b1;
          end
          // An ack landing in the final timeout cycle still completes normally
          if (bus.wb_ack_i) begin
            rdata <= we_q ? 32'd0 : bus.wb_dat_i;
            err   <= 1'b0;
            cyc_q <= 1'b0;
            state <= RESP;
          end else if (TIMEOUT_EN && (timer == TIMER_LAST)) begin
            rdata <= '0;
            err   <= 1'b1;
            cyc_q <= 1'b0;
            if (timeout_count != 8'hFF) begin
              timeout_count <= timeout_count + 8'd1;
            end
            state <= RESP;
          end
        end
        RESP: begin
          if (!gsel || gen) begin
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.wb_cyc_o = cyc_q;
  assign bus.wb_stb_o = cyc_q;
  assign bus.wb_we_o  = we_q;
  assign bus.wb_sel_o = 4'hF;
  assign bus.wb_adr_o = adr_q;
  assign bus.wb_dat_o = wdat_q;

  // Only the granted port ever sees a response; the other is held in wait states
  assign bus.s0_pready  = resp_hit & ~grant;
  assign bus.s0_prdata  = (resp_hit & ~grant) ? rdata : 32'd0;
  assign bus.s0_pslverr = resp_hit & ~grant & err;
  assign bus.s1_pready  = resp_hit & grant;
  assign bus.s1_prdata  = (resp_hit & grant) ? rdata : 32'd0;
  assign bus.s1_pslverr = resp_hit & grant & err;

endmodule

// File: tb/tb_hk_apb_arbiter.sv
// Self-checking bench for hk_apb_arbiter: two APB masters and a WB responder,
// checked against a transaction-level round-robin / timeout reference model.
module tb_hk_apb_arbiter;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] timeout_count;

  hk_apb_arbiter_if #(.W_ADDR(32)) bus ();

  hk_apb_arbiter #(.W_ADDR(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .timeout_count (timeout_count)
  );

  always #5 clk = ~clk;

  logic        psel    [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic [31:0] paddr   [2];
  logic [31:0] pwdata  [2];
  logic        rdy     [2];
  logic [31:0] rd      [2];
  logic        er      [2];

  assign bus.s0_psel = psel[0];    assign bus.s1_psel = psel[1];
  assign bus.s0_penable = penable[0]; assign bus.s1_penable = penable[1];
  assign bus.s0_pwrite = pwrite[0];  assign bus.s1_pwrite = pwrite[1];
  assign bus.s0_paddr = paddr[0];   assign bus.s1_paddr = paddr[1];
  assign bus.s0_pwdata = pwdata[0];  assign bus.s1_pwdata = pwdata[1];
  assign rdy[0] = bus.s0_pready;    assign rdy[1] = bus.s1_pready;
  assign rd[0]  = bus.s0_prdata;    assign rd[1]  = bus.s1_prdata;
  assign er[0]  = bus.s0_pslverr;   assign er[1]  = bus.s1_pslverr;

  int vectors = 0;
  int miscompares = 0;

  // Per-port transaction lists and per-served-slot WB behaviour
  logic [31:0] addr_q [2][16];
  logic [31:0] data_q [2][16];
  logic        wr_q   [2][16];
  int          cnt    [2];
  int          delay_q [64];
  logic [31:0] wbd_q   [64];
  int          order   [64];
  int          last_served;
  int          tc_model;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic add_txn(input int port, input logic [31:0] a, input logic [31:0] d, input logic w);
    addr_q[port][cnt[port]] = a;
    data_q[port][cnt[port]] = d;
    wr_q[port][cnt[port]]   = w;
    cnt[port]++;
  endtask

  task automatic fill_slots(input int lo, input int hi);
    for (int i = 0; i < 64; i++) begin
      delay_q[i] = $urandom_range(hi, lo);
      wbd_q[i]   = $urandom();
    end
  endtask

  task automatic setup_port(input int k, input int i);
    psel[k]    = 1'b1;
    penable[k] = 1'b0;
    paddr[k]   = addr_q[k][i];
    pwdata[k]  = data_q[k][i];
    pwrite[k]  = wr_q[k][i];
  endtask

  task automatic idle_inputs();
    for (int k = 0; k < 2; k++) begin
      psel[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0;
      paddr[k] = '0; pwdata[k] = '0;
    end
    bus.wb_ack_i = 1'b0;
    bus.wb_dat_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    #3;
    checkOutput("rst_cyc", 32'(bus.wb_cyc_o), 0);
    checkOutput("rst_stb", 32'(bus.wb_stb_o), 0);
    checkOutput("rst_we", 32'(bus.wb_we_o), 0);
    checkOutput("rst_sel", 32'(bus.wb_sel_o), 32'hF);
    checkOutput("rst_adr", bus.wb_adr_o, 0);
    checkOutput("rst_dat", bus.wb_dat_o, 0);
    checkOutput("rst_tcount", 32'(timeout_count), 0);
    checkOutput("rst_pready", {30'd0, rdy[1], rdy[0]}, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    last_served = 1;
    tc_model = 0;
  endtask

  // Runs the queued transactions with both masters re-requesting immediately after each completion
  task automatic applyStimulus();
    int total;
    int r[2];
    int last;
    int idx[2];
    bit done[2];
    int n;
    int stb_len;
    int cyc;
    total = cnt[0] + cnt[1];
    r[0] = cnt[0]; r[1] = cnt[1];
    last = last_served;
    for (int s = 0; s < total; s++) begin
      int p;
      if (r[0] > 0 && r[1] > 0) p = 1 - last;
      else p = (r[0] > 0) ? 0 : 1;
      order[s] = p;
      r[p]--;
      last = p;
    end
    idx[0] = 0; idx[1] = 0; done[0] = 0; done[1] = 0;
    n = 0; stb_len = 0; cyc = 0;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) if (cnt[k] > 0) setup_port(k, 0);
    while (n < total && cyc < 400) begin
      if (bus.wb_stb_o === 1'b1) begin
        int p;
        p = order[n];
        if (stb_len == 0) begin
          checkOutput("wb_adr", bus.wb_adr_o, addr_q[p][idx[p]]);
          checkOutput("wb_dat_o", bus.wb_dat_o, data_q[p][idx[p]]);
          checkOutput("wb_we", 32'(bus.wb_we_o), 32'(wr_q[p][idx[p]]));
          checkOutput("wb_sel", 32'(bus.wb_sel_o), 32'hF);
        end
        bus.wb_ack_i = (stb_len == delay_q[n]);
        bus.wb_dat_i = bus.wb_ack_i ? wbd_q[n] : $urandom();
        stb_len++;
      end else begin
        bus.wb_ack_i = 1'b0;
        bus.wb_dat_i = $urandom();
      end
      #2;
      for (int k = 0; k < 2; k++) begin
        if (rdy[k] === 1'b1) begin
          int p;
          bit timed_out;
          logic [31:0] exp_data;
          p = order[n];
          timed_out = (delay_q[n] >= TO);
          exp_data = (wr_q[p][idx[p]] || timed_out) ? 32'd0 : wbd_q[n];
          if (timed_out && tc_model < 255) tc_model++;
          checkOutput("grant_port", k, p);
          checkOutput("prdata", rd[k], exp_data);
          checkOutput("pslverr", 32'(er[k]), 32'(timed_out));
          checkOutput("stb_len", stb_len, timed_out ? TO : delay_q[n] + 1);
          checkOutput("tcount", 32'(timeout_count), tc_model);
          if (n == 0) checkOutput("latency", cyc, timed_out ? TO + 1 : delay_q[n] + 2);
          done[k] = 1'b1;
          last_served = k;
          n++;
          stb_len = 0;
        end else begin
          checkOutput("idle_resp", rd[k] | 32'(er[k]), 0);
        end
      end
      @(posedge clk); #1;
      cyc++;
      for (int k = 0; k < 2; k++) begin
        if (done[k]) begin
          done[k] = 1'b0;
          idx[k]++;
          if (idx[k] < cnt[k]) setup_port(k, idx[k]);
          else begin psel[k] = 1'b0; penable[k] = 1'b0; end
        end else if (psel[k] && !penable[k]) begin
          penable[k] = 1'b1;
        end
      end
    end
    if (n < total) checkOutput("cycle_budget", n, total);
    idle_inputs();
    cnt[0] = 0; cnt[1] = 0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    cnt[0] = 0; cnt[1] = 0;
    do_reset();

    // Single read, immediate ack
    fill_slots(0, 0);
    wbd_q[0] = 32'h1234_5678;
    add_txn(0, 32'h2600_0004, 32'h0, 1'b0);
    applyStimulus();

    // Simultaneous writes after reset: port 0 first, then port 1
    do_reset();
    fill_slots(0, 0);
    add_txn(0, 32'h2600_0010, 32'hA, 1'b1);
    add_txn(1, 32'h2600_0020, 32'hB, 1'b1);
    applyStimulus();

    // Continuous contention: grants must alternate
    fill_slots(0, 2);
    for (int i = 0; i < 4; i++) begin
      add_txn(0, $urandom(), $urandom(), 1'($urandom()));
      add_txn(1, $urandom(), $urandom(), 1'($urandom()));
    end
    applyStimulus();

    // No ack -> timeout; ack in the last allowed BUS cycle -> normal completion
    fill_slots(0, 0);
    delay_q[0] = 9;
    delay_q[1] = TO - 1;
    add_txn(0, 32'h2600_0030, 32'h0, 1'b0);
    add_txn(0, 32'h2600_0034, 32'h0, 1'b0);
    applyStimulus();

    // Randomized traffic mix
    for (int it = 0; it < 30; it++) begin
      int c0;
      int c1;
      c0 = $urandom_range(3, 0);
      c1 = $urandom_range(3, 0);
      if (c0 + c1 == 0) c0 = 1;
      fill_slots(0, 6);
      for (int i = 0; i < c0; i++) add_txn(0, $urandom(), $urandom(), 1'($urandom()));
      for (int i = 0; i < c1; i++) add_txn(1, $urandom(), $urandom(), 1'($urandom()));
      applyStimulus();
    end

    // Reset asserted mid BUS phase
    idle_inputs();
    bus.wb_dat_i = 32'h5555_AAAA;
    paddr[1] = 32'h2600_0040;
    @(posedge clk); #1;
    psel[1] = 1'b1;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    #1;
    checkOutput("bus_cyc_before_rst", 32'(bus.wb_cyc_o), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_cyc", 32'(bus.wb_cyc_o), 0);
    checkOutput("async_stb", 32'(bus.wb_stb_o), 0);
    checkOutput("async_pready", {30'd0, rdy[1], rdy[0]}, 0);
    checkOutput("async_tcount", 32'(timeout_count), 0);
    idle_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_served = 1;
    tc_model = 0;
    fill_slots(0, 0);
    add_txn(0, 32'h2600_0050, 32'h0, 1'b0);
    add_txn(1, 32'h2600_0054, 32'h0, 1'b0);
    applyStimulus();

    // Drive the counter into saturation
    for (int i = 0; i < 256; i++) begin
      fill_slots(9, 9);
      add_txn(i % 2, $urandom(), $urandom(), 1'($urandom()));
      applyStimulus();
    end
    checkOutput("tcount_saturated", 32'(timeout_count), 255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
